// File: rtl/acc_drain_pkg.sv
// Shared types, widths and arithmetic helpers for the accumulator drain / requantizer.
// Widths are fixed here so q_cfg_t and the helpers agree with every user.
package acc_drain_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MULT_WIDTH = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int ZP_WIDTH   = OUT_WIDTH + 1;
  localparam int PROD_WIDTH = DATA_WIDTH + MULT_WIDTH;
  localparam int SUM_WIDTH  = DATA_WIDTH + 2;

  typedef struct packed {
    logic signed [MULT_WIDTH-1:0] mult;
    logic        [4:0]            shift;
    logic signed [ZP_WIDTH-1:0]   zp;
    logic signed [OUT_WIDTH-1:0]  act_min;
    logic signed [OUT_WIDTH-1:0]  act_max;
  } q_cfg_t;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} drain_state_e;

  // Signed add that saturates to the DATA_WIDTH range instead of wrapping.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = s[DATA_WIDTH-1:0];
  endfunction

  // Round-half-up arithmetic right shift by (MULT_WIDTH-1+shift); one guard bit avoids overflow.
  function automatic logic signed [SUM_WIDTH-1:0] round_shift(
    input logic signed [PROD_WIDTH-1:0] prod,
    input logic        [4:0]            shift
  );
    logic signed [PROD_WIDTH:0] t;
    logic        [6:0]          sh;
    sh         = 7'(MULT_WIDTH - 1) + 7'(shift);
    t          = '0;
    t[sh-7'd1] = 1'b1;
    t          = t + {prod[PROD_WIDTH-1], prod};
    t          = t >>> sh;
    return t[SUM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/acc_drain_requant_if.sv
// Output element stream of the drain: valid/ready with a last-lane marker.
interface acc_drain_requant_if;
  import acc_drain_pkg::*;

  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/requant_pipe.sv
// Valid/ready requantization pipeline: S1 multiply, S2 round/shift/zp/clamp.
// ACC_DRAIN_BIAS_EN adds a leading saturating bias-add stage.
module requant_pipe
  import acc_drain_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [DATA_WIDTH-1:0] i_data,
`ifdef ACC_DRAIN_BIAS_EN
  input  logic signed [DATA_WIDTH-1:0] i_bias,
`endif
  input  logic                         i_last,
  input  q_cfg_t                       i_cfg,
  acc_drain_requant_if.master          m_out
);

  logic                         r_s1_valid, r_s1_last;
  logic signed [PROD_WIDTH-1:0] r_s1_prod;
  logic                         r_s2_valid, r_s2_last;
  logic signed [OUT_WIDTH-1:0]  r_s2_data;

  logic                         w_s1_en, w_s2_en, w_s1_in_valid, w_s1_in_last;
  logic signed [DATA_WIDTH-1:0] w_s1_a;
  logic signed [PROD_WIDTH-1:0] w_a_ext, w_m_ext;
  logic signed [SUM_WIDTH-1:0]  w_r, w_v, w_min, w_max;
  logic signed [OUT_WIDTH-1:0]  w_q;

  // A stage loads when it is empty or its current element is leaving this cycle.
  assign w_s2_en = ~r_s2_valid | m_out.out_ready;
  assign w_s1_en = ~r_s1_valid | w_s2_en;

`ifdef ACC_DRAIN_BIAS_EN
  logic                         r_s0_valid, r_s0_last;
  logic signed [DATA_WIDTH-1:0] r_s0_sum;

  assign o_ready = ~r_s0_valid | w_s1_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_sum   <= '0;
    end else if (o_ready) begin
      r_s0_valid <= i_valid;
      if (i_valid) begin
        r_s0_sum  <= sat_add(i_data, i_bias);
        r_s0_last <= i_last;
      end
    end
  end

  assign w_s1_in_valid = r_s0_valid;
  assign w_s1_in_last  = r_s0_last;
  assign w_s1_a        = r_s0_sum;
`else
  assign o_ready       = w_s1_en;
  assign w_s1_in_valid = i_valid;
  assign w_s1_in_last  = i_last;
  assign w_s1_a        = i_data;
`endif

  assign w_a_ext = {{MULT_WIDTH{w_s1_a[DATA_WIDTH-1]}}, w_s1_a};
  assign w_m_ext = {{DATA_WIDTH{i_cfg.mult[MULT_WIDTH-1]}}, i_cfg.mult};

  // NOTE: sequential state uses <= so every stage samples pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_s1_in_valid;
      if (w_s1_in_valid) begin
        r_s1_prod <= w_a_ext * w_m_ext;
        r_s1_last <= w_s1_in_last;
      end
    end
  end

  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    w_r   = round_shift(r_s1_prod, i_cfg.shift);
    w_v   = w_r + {{(SUM_WIDTH-ZP_WIDTH){i_cfg.zp[ZP_WIDTH-1]}}, i_cfg.zp};
    w_min = {{(SUM_WIDTH-OUT_WIDTH){i_cfg.act_min[OUT_WIDTH-1]}}, i_cfg.act_min};
    w_max = {{(SUM_WIDTH-OUT_WIDTH){i_cfg.act_max[OUT_WIDTH-1]}}, i_cfg.act_max};
    w_q   = w_v[OUT_WIDTH-1:0];
    if (w_v > w_max || w_min > w_max) w_q = i_cfg.act_max;
    else if (w_v < w_min)             w_q = i_cfg.act_min;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_q;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign m_out.out_valid = r_s2_valid;
  assign m_out.out_data  = r_s2_data;
  assign m_out.out_last  = r_s2_last;

endmodule

// File: rtl/acc_drain_requant.sv
// Drains all accumulator lanes on tile completion and streams requantized elements.
// ACC_DRAIN_BIAS_EN adds bias_i (read at acc_read_ptr_o) and one pipeline stage.
module acc_drain_requant
  import acc_drain_pkg::*;
#(
  parameter int STAGE_NUM = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] acc_data_i,
`ifdef ACC_DRAIN_BIAS_EN
  input  logic signed [DATA_WIDTH-1:0] bias_i,
`endif
  input  logic                         acc_valid_i,
  input  logic                         acc_calc_done_i,
  output logic [$clog2(STAGE_NUM)-1:0] acc_read_ptr_o,
  output logic                         drain_busy_o,
  input  logic signed [MULT_WIDTH-1:0] q_mult_i,
  input  logic        [4:0]            q_shift_i,
  input  logic signed [ZP_WIDTH-1:0]   q_zp_i,
  input  logic signed [OUT_WIDTH-1:0]  q_act_min_i,
  input  logic signed [OUT_WIDTH-1:0]  q_act_max_i,
  acc_drain_requant_if.master          out_if,
  output logic                         drain_done_o,
  output logic                         overrun_o
);

  localparam int PTR_W = $clog2(STAGE_NUM);

  drain_state_e     r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_trig_d, r_busy, r_done, r_overrun;
  q_cfg_t           r_cfg;

  logic w_trig, w_in_ready, w_issue, w_last_lane, w_last_hs;

  assign w_trig      = acc_valid_i & acc_calc_done_i & ~r_trig_d;
  assign w_issue     = (r_state == DRAIN) & w_in_ready;
  assign w_last_lane = (r_ptr == PTR_W'(STAGE_NUM - 1));
  assign w_last_hs   = out_if.out_valid & out_if.out_ready & out_if.out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_trig_d  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_cfg     <= '0;
    end else begin
      r_trig_d  <= acc_valid_i & acc_calc_done_i;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state <= DRAIN;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
            r_cfg   <= '{mult: q_mult_i, shift: q_shift_i, zp: q_zp_i,
                         act_min: q_act_min_i, act_max: q_act_max_i};
          end
        end
        DRAIN: begin
          r_overrun <= w_trig;
          if (w_issue) begin
            r_ptr <= w_last_lane ? '0 : r_ptr + 1'b1;
            if (w_last_lane) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_overrun <= w_trig;
          if (w_last_hs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  requant_pipe u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_state == DRAIN),
    .o_ready (w_in_ready),
    .i_data  (acc_data_i),
`ifdef ACC_DRAIN_BIAS_EN
    .i_bias  (bias_i),
`endif
    .i_last  (w_last_lane),
    .i_cfg   (r_cfg),
    .m_out   (out_if)
  );

  assign acc_read_ptr_o = r_ptr;
  assign drain_busy_o   = r_busy;
  assign drain_done_o   = r_done;
  assign overrun_o      = r_overrun;

endmodule
